// File: rtl/obi_reg_secondary.sv
// OBI responder terminating a single-clock bus into a bank of 32-bit registers.
// Byte-enable writes, configurable grant wait states, error response on out-of-range addresses.
module obi_reg_secondary #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned GNT_WAIT  = 0,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW  = $clog2(NUM_REGS);
  localparam int unsigned WCW = ($clog2(GNT_WAIT + 1) < 1) ? 1 : $clog2(GNT_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(GNT_WAIT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WCW-1:0]   r_wcnt;
  logic [WCW-1:0]   w_wcnt_nxt;
  logic             w_gnt;
  logic             w_accept;
  logic             w_hit;
  logic [AW-1:0]    w_index;
  logic [31:0]      r_regs [NUM_REGS];
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             r_err;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Word index from the byte address; the low two bits are don't-care.
  assign w_index  = addr_i[AW+1:2];
  assign w_hit    = ((addr_i >> (AW + 2)) == 32'd0);
  // Grant is held low for the whole reset, even with GNT_WAIT=0 and req_i high.
  assign gnt_o    = w_gnt & rst_ni;
  assign w_accept = req_i & gnt_o;

  // Grant FSM state and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_wcnt  <= {WCW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_gnt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (GNT_WAIT == 0) begin
            w_gnt = 1'b1;
          end else begin
            w_wcnt_nxt  = WCW'(1'b1);
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_wcnt_nxt = {WCW{1'b0}};
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          // Request withdrawn before grant: abandon without a transaction.
          w_wcnt_nxt  = {WCW{1'b0}};
          w_state_nxt = S_IDLE;
        end else if (r_wcnt == WAIT_MAX) begin
          w_gnt       = 1'b1;
          w_wcnt_nxt  = {WCW{1'b0}};
          w_state_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt + WCW'(1'b1);
        end
      end
      default: begin
        w_wcnt_nxt  = {WCW{1'b0}};
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Register bank with byte-merged writes on accepted in-range writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_accept && w_hit && we_i) begin
      r_regs[w_index] <= merge_bytes(r_regs[w_index], wdata_i, be_i);
    end
  end

  // Response channel: one registered pulse per accepted transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0000_0000;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_rvalid <= 1'b1;
      r_err    <= ~w_hit;
      if (w_hit && !we_i) begin
        r_rdata <= r_regs[w_index];
      end else begin
        r_rdata <= 32'h0000_0000;
      end
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: doc/obi_reg_secondary.md
# obi_reg_secondary

OBI secondary (responder) endpoint that terminates a single-clock OBI bus into a bank of 32-bit registers. It sits at the peripheral end of the OBI fabric, downstream of interconnect or CDC bridges, and answers every granted transaction with exactly one response. It supports byte-enable writes, a configurable number of grant wait states and an error response for out-of-range addresses.

## Interface
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256; AW = clog2(NUM_REGS)
- GNT_WAIT, 0, cycles `req_i` must be held before `gnt_o` asserts; 0..15
- RESET_VAL, 32'h0000_0000, reset value of every register
- clk_i  input  1  single clock for all logic
- rst_ni  input  1  asynchronous, active-low reset
- req_i  input  1  request from primary
- gnt_o  output  1  grant; address phase completes on req_i && gnt_o
- addr_i  input  32  byte address
- we_i  input  1  1 = write, 0 = read
- be_i  input  4  byte enables; be_i[k] selects wdata_i[8k+7:8k]
- wdata_i  input  32  write data
- rvalid_o  output  1  one-cycle response pulse
- rdata_o  output  32  read data, valid with rvalid_o
- err_o  output  1  error flag, valid with rvalid_o

## Operation
- Decode: index = addr_i[AW+1:2]; addr_i[1:0] ignored; hit when addr_i[31:AW+2] == 0, else miss.
- Wait counter `wcnt` (width clog2(GNT_WAIT+1), min 1 bit).
- States: IDLE, WAIT.
  - IDLE: req_i=0 -> stay. req_i=1 and GNT_WAIT=0 -> gnt_o=1 combinationally, stay IDLE. req_i=1 and GNT_WAIT>0 -> wcnt<=1, go WAIT.
  - WAIT: gnt_o = (req_i && wcnt == GNT_WAIT). On grant -> wcnt<=0, IDLE. req_i=0 -> wcnt<=0, IDLE (defensive; no transaction). Else wcnt<=wcnt+1.
- gnt_o is 0 whenever req_i is 0 and always 0 in reset.
- On accept (req_i && gnt_o), sampled at rising clk_i:
  - write hit: for each k with be_i[k]=1, reg[index][8k+7:8k] <= wdata_i byte; other bytes unchanged. be_i=0 is a legal no-op write.
  - read hit: rdata_o <= reg[index].
  - write hit response: rdata_o <= 0, err_o <= 0.
  - miss (read or write): no register changes, rdata_o <= 0, err_o <= 1.
  - all accepts: rvalid_o <= 1 next cycle.
- No accept in a cycle -> rvalid_o <= 0, err_o <= 0; rdata_o holds last value.
- Address/we/be/wdata sampled only at the accept edge; changes during WAIT are ignored until grant.
- Responses are strictly in order. No rready: the primary must accept rvalid_o unconditionally.

## Timing
- Reset (rst_ni=0, asynchronous): state=IDLE, wcnt=0, rvalid_o=0, err_o=0, rdata_o=0, all registers=RESET_VAL. gnt_o=0 while rst_ni=0.
- Reset asserted mid-WAIT or with a response pending: the transaction and response are dropped. After release, the first grant needs GNT_WAIT more held cycles.
- Response latency: rvalid_o is high in the cycle immediately after the accept edge, for exactly one cycle per transaction.
- Throughput with GNT_WAIT=0: one transaction per cycle, back-to-back. rvalid_o stays high continuously while req_i is held.
- Throughput with GNT_WAIT=N>0: with req_i held, grants occur in cycles N, 2N+1, 3N+2, ... counted from the first req cycle (cycle 0). Each transaction re-incurs N wait cycles.
- Read-after-write to the same register on consecutive accepts returns the newly written value, byte-merged.
- Write data is visible in the register one edge after the accept.

## Test plan
- Reset values: after reset, read addr 0x0 and addr 0x3C (NUM_REGS=16) -> rvalid_o one cycle after gnt, rdata_o=RESET_VAL, err_o=0.
- Byte enables: write 0xAABBCCDD be=4'hF to 0x4, then write 0x11223344 be=4'b0101 to 0x4, then read 0x4 -> rdata_o=0xAA22CC44. Back-to-back at GNT_WAIT=0 gives rvalid_o high for 3 consecutive cycles.
- Error path: write 0xDEADBEEF to 0x40 (NUM_REGS=16) -> rvalid_o=1, err_o=1, rdata_o=0. Then read 0x0 -> unchanged value, err_o=0. Also read 0x8000_0000 -> err_o=1.
- Wait states: GNT_WAIT=3, req_i held from cycle 0 for two reads -> gnt_o high only in cycles 3 and 7, rvalid_o in cycles 4 and 8. Drop req_i in cycle 2 of a new request -> no gnt_o, no rvalid_o, and wcnt restarts.
- Reset mid-operation: GNT_WAIT=2, assert rst_ni=0 asynchronously between clock edges during WAIT, and separately in the cycle after a write accept -> gnt_o, rvalid_o and err_o drop immediately, and the written register reads RESET_VAL afterwards.
- Misaligned address: read 0x7 after writing 0x12345678 to 0x4 -> rdata_o=0x12345678, err_o=0.
